my_dmux4way16_reg: RTL

Registered 4-way 16-bit demultiplexer: the inverse of the 4-way 16-bit mux. It steers one input word per cycle to one of four output channels (a/b/c/d) selected by `sel`. Each channel has a one-entry holding register, a valid/ready handshake and a delivered-word counter. The block sits where one producer stream is fanned out to four consumers.

---
 rtl/my_dmux4way16_reg_pkg.sv | 23 ++
 rtl/my_way_slot.sv | 42 ++++
 rtl/my_dmux4way16_reg.sv | 61 ++++++
 3 files changed

// File: rtl/my_dmux4way16_reg_pkg.sv
// Shared constants for the registered 4-way demultiplexer: way count, select
// encodings, default widths and the select-to-one-hot decode.
package my_dmux_pkg;

  localparam int WAYS  = 4;
  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_A = 2'b00;
  localparam logic [SEL_W-1:0] SEL_B = 2'b01;
  localparam logic [SEL_W-1:0] SEL_C = 2'b10;
  localparam logic [SEL_W-1:0] SEL_D = 2'b11;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = 8;

  function automatic logic [WAYS-1:0] sel_decode(input logic [SEL_W-1:0] s);
    logic [WAYS-1:0] hot;
    hot    = '0;
    hot[s] = 1'b1;
    return hot;
  endfunction

endpackage

// File: rtl/my_way_slot.sv
// One demux channel: one-entry holding register with valid flag and wrapping delivered-word counter.
// Latency 1 cycle from load; accepts a new word while full if the consumer drains it the same cycle.
module my_way_slot
  import my_dmux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             can_load
);

  logic deliver;

  assign deliver  = valid && ready;
  assign can_load = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      valid <= 1'b0;
      count <= '0;
    end else begin
      // Data only changes on a load; a drain leaves the last word visible.
      if (load) begin
        dout <= din;
      end
      valid <= load || (valid && !ready);
      if (deliver) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/my_dmux4way16_reg.sv
// Registered 4-way demux: steers one word per cycle to channel a/b/c/d by sel, 1-cycle latency.
// in_ready drops only while sel points at a full channel whose consumer is not ready.
module my_dmux4way16_reg
  import my_dmux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     c,
  output logic [WIDTH-1:0]     d,
  output logic [WAYS-1:0]      out_valid,
  input  logic [WAYS-1:0]      out_ready,
  output logic [WAYS*CNT_W-1:0] count
);

  logic [WAYS-1:0]  sel_hot;
  logic [WAYS-1:0]  load;
  logic [WAYS-1:0]  can_load;
  logic [WAYS-1:0]  slot_valid;
  logic [WIDTH-1:0] slot_data [WAYS];
  logic [CNT_W-1:0] slot_cnt  [WAYS];
  logic             accept;

  assign sel_hot  = sel_decode(sel);
  assign in_ready = can_load[sel];
  assign accept   = in_valid && in_ready;
  assign load     = accept ? sel_hot : '0;

  for (genvar i = 0; i < WAYS; i++) begin : g_slot
    my_way_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[i]),
      .din      (in),
      .ready    (out_ready[i]),
      .dout     (slot_data[i]),
      .valid    (slot_valid[i]),
      .count    (slot_cnt[i]),
      .can_load (can_load[i])
    );
    assign count[i*CNT_W +: CNT_W] = slot_cnt[i];
  end

  assign a         = slot_data[SEL_A];
  assign b         = slot_data[SEL_B];
  assign c         = slot_data[SEL_C];
  assign d         = slot_data[SEL_D];
  assign out_valid = slot_valid;

endmodule
